// File: rtl/handshake_reader_if.sv
// Bundle of the host-side 4-phase handshake and the consumer-side FIFO bus of handshake_reader.
// Parameters: DATA_W (data word width), DEPTH (FIFO entries, power of two, >= 2).
// Modports:
//   slave  - the reader. It takes the host word, tags, request and accept_en. It drives the ack,
//            the FIFO head, the hash-reset pulse and the occupancy.
//   master - the environment (host pin plus consumer FSM), the mirror image of slave.
interface handshake_reader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  logic [DATA_W-1:0]        input_data;
  logic                     is_key;
  logic                     reset_hash;
  logic                     input_request;
  logic                     input_ack;
  logic                     accept_en;
  logic [DATA_W-1:0]        out_data;
  logic                     out_is_key;
  logic                     out_valid;
  logic                     out_ready;
  logic                     reset_hash_pulse;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  input_data, is_key, reset_hash, input_request, accept_en, out_ready,
    output input_ack, out_data, out_is_key, out_valid, reset_hash_pulse, fifo_count
  );

  modport master (
    output input_data, is_key, reset_hash, input_request, accept_en, out_ready,
    input  input_ack, out_data, out_is_key, out_valid, reset_hash_pulse, fifo_count
  );
endinterface

// File: rtl/handshake_reader.sv
// handshake_reader: captures host words over a 4-phase request/ack handshake into a small FIFO.
// A word flagged reset_hash becomes a one-cycle reset_hash_pulse and is not queued.
// Ports:
//   clk  - sole clock, rising edge.
//   nrst - asynchronous active-low reset.
//   bus  - handshake_reader_if.slave. Carries the host handshake and the consumer FIFO bus.
// Optional feature: define READER_SYNC_EN to pass input_request through a 2-flop synchronizer.
//   With it, the pin-to-ack latency is 3 cycles. Without it, the latency is 1 cycle.
module handshake_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input logic               clk,
  input logic               nrst,
  handshake_reader_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StDrain, StWaitReq, StAck} state_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              pulse_q, pulse_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              key_q, key_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic              req_s, push, pop, full;

`ifdef READER_SYNC_EN
  logic sync1_q, sync2_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.input_request;
      sync2_q <= sync1_q;
    end
  end
  assign req_s = sync2_q;
`else
  assign req_s = bus.input_request;
`endif

  assign full = (count_q == CntW'(DEPTH));
  assign pop  = (count_q != '0) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pulse_d = 1'b0;
    unique case (state_q)
      // After reset, a request still held high belongs to a word that was already taken.
      StDrain: if (!req_s) state_d = StWaitReq;
      StWaitReq: begin
        if (req_s && bus.accept_en) begin
          if (bus.reset_hash) begin
            pulse_d = 1'b1;
            state_d = StAck;
          end else if (!full) begin
            push    = 1'b1;
            state_d = StAck;
          end
        end
      end
      StAck: if (!req_s) state_d = StWaitReq;
      default: state_d = StDrain;
    endcase
    ack_d = (state_d == StAck);

    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);

    // The head is registered so that it holds its last value once the FIFO empties.
    // A word pushed into the slot that becomes the head bypasses the memory.
    data_d = data_q;
    key_d  = key_q;
    if (count_d != '0) begin
      if (push && (wptr_q == rptr_d)) {key_d, data_d} = {bus.is_key, bus.input_data};
      else                            {key_d, data_d} = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StDrain;
      ack_q   <= 1'b0;
      pulse_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      pulse_q <= pulse_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      key_q   <= key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.is_key, bus.input_data};
  end

  assign bus.input_ack        = ack_q;
  assign bus.reset_hash_pulse = pulse_q;
  assign bus.out_data         = data_q;
  assign bus.out_is_key       = key_q;
  assign bus.out_valid        = (count_q != '0);
  assign bus.fifo_count       = count_q;
endmodule

// File: doc/handshake_reader.md
HANDSHAKE_READER -- requirements
Module: handshake_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of captured data word.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-003 SHALL have ports: clk  in  1  sole clock, all flops on rising edge.
REQ-004 nrst  in  1  asynchronous, active-low reset.
REQ-005 input_data  in  DATA_W  host data word, stable while input_request high.
REQ-006 is_key  in  1  host tag: word is key material.
REQ-007 reset_hash  in  1  host command: reset hash instead of sending data.
REQ-008 input_request  in  1  4-phase handshake request from chip pin.
REQ-009 input_ack  out  1  4-phase handshake acknowledge to chip pin.
REQ-010 accept_en  in  1  high when the consumer FSM is idle and a capture is permitted.
REQ-011 out_data  out  DATA_W  FIFO head data.
REQ-012 out_is_key  out  1  FIFO head key tag.
REQ-013 out_valid  out  1  FIFO non-empty.
REQ-014 out_ready  in  1  consumer pops head when out_valid and out_ready are both high.
REQ-015 reset_hash_pulse  out  1  single-cycle hash reset to hash generator.
REQ-016 fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 req_s SHALL be the conditioned request (see Configuration); all handshake decisions use req_s.
REQ-018 FSM states SHALL be: DRAIN, WAIT_REQ, ACK.
REQ-019 DRAIN -> WAIT_REQ when req_s = 0; input_ack = 0 in DRAIN.
REQ-020 In WAIT_REQ with req_s = 1, accept_en = 1, reset_hash = 1: next cycle reset_hash_pulse = 1 for exactly one cycle, no FIFO push, -> ACK.
REQ-021 In WAIT_REQ with req_s = 1, accept_en = 1, reset_hash = 0, FIFO not full: push {is_key, input_data}, -> ACK; reset_hash takes precedence over data.
REQ-022 In WAIT_REQ with FIFO full and reset_hash = 0, or accept_en = 0: remain in WAIT_REQ, no ack, no push; the host stalls.
REQ-023 input_ack SHALL be registered, equal to 1 exactly while in ACK.
REQ-024 ACK -> WAIT_REQ when req_s = 0; input_ack falls on the same edge.
REQ-025 A pushed word SHALL appear at out_data with out_valid = 1 on the cycle after the push edge.
REQ-026 Push and pop on the same cycle SHALL leave fifo_count unchanged; pop on empty and push on full SHALL never occur.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
REQ-028 out_data and out_is_key SHALL hold their last value when out_valid = 0.
REQ-029 A reset_hash capture SHALL NOT flush FIFO contents.

Reset
REQ-030 On nrst low, asynchronously: state = DRAIN; input_ack, reset_hash_pulse, out_valid, out_is_key = 0; out_data = 0; fifo_count = 0; pointers and sync flops = 0.
REQ-031 Reset mid-handshake with the host still holding request high SHALL NOT cause a duplicate capture; DRAIN waits for req_s = 0.

Configuration
REQ-032 Macro READER_SYNC_EN defined: input_request passes through a 2-flop synchronizer, so req_s lags the pin by 2 cycles, and the pin-to-ack latency is 3 cycles.
REQ-033 READER_SYNC_EN undefined: req_s = input_request directly, and the pin-to-ack latency is 1 cycle; all other behaviour is identical.

Verification
REQ-034 Single data word: with DATA_W = 8 and READER_SYNC_EN undefined, drive 0xA5 with is_key = 1 and request high -> ack rises the next cycle; out_data = 0xA5, out_is_key = 1, out_valid = 1; fifo_count = 1.
REQ-035 Reset hash with input_data = 0x3C -> reset_hash_pulse high for exactly 1 cycle; fifo_count stays 0; no out_valid.
REQ-036 Full stall: with DEPTH = 4 and out_ready = 0, send 5 words 0x01..0x05 -> the 5th request gets no ack; fifo_count = 4. Pop once -> the 5th is acked, and the pop order is 0x01..0x05.
REQ-037 Simultaneous push and pop at fifo_count = 2 -> fifo_count stays 2, and the data order is preserved across pointer wrap.
REQ-038 Assert nrst while in ACK with request held high, then release -> ack = 0; no new push until the request falls and rises again.
REQ-039 With READER_SYNC_EN defined, a request rise -> ack rises 3 cycles later; accept_en = 0 -> no ack indefinitely.
